// File: rtl/prescaled_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_counter_pkg
// Purpose  : Shared widths, direction encodings and next-count function for
//            the prescaled up/down counter (honours PRESCALED_COUNTER_SATURATE_EN).
// Revision : 1.0 - initial release
// ============================================================================
package prescaled_counter_pkg;

  localparam int N_DEF     = 8;
  localparam int PW_DEF    = 23;
  localparam int CNT_W_MAX = 32;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic                 wrap;
    logic [CNT_W_MAX-1:0] q;
  } count_res_t;

  // Operands are zero-extended N-bit values; the result never exceeds
  // max(q, mod_max), so the caller can truncate back to N bits safely.
  function automatic count_res_t next_count(input logic [CNT_W_MAX-1:0] q,
                                            input logic                 up,
                                            input logic [CNT_W_MAX-1:0] mod_max);
    count_res_t r;
    r.wrap = 1'b0;
    r.q    = q;
    if (up == DIR_UP) begin
      if (q >= mod_max) begin
        r.wrap = 1'b1;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        r.q    = q;
`else
        r.q    = '0;
`endif
      end else begin
        r.q = q + CNT_W_MAX'(1);
      end
    end else begin
      if (q == '0) begin
        r.wrap = 1'b1;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        r.q    = '0;
`else
        r.q    = mod_max;
`endif
      end else begin
        r.q = q - CNT_W_MAX'(1);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prescaled_updown_counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_prescaler
// Purpose  : Clock-enable prescaler; step is high once every div+1 enabled clocks.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_prescaler #(
  parameter int PW = 23
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          step
);

  logic [PW-1:0] r_pcnt;
  logic          w_hit;

  // div is compared live: if it drops below r_pcnt the counter runs the full
  // PW-bit range and wraps before matching again.
  assign w_hit = (r_pcnt == div);
  assign step  = en & ~clr & w_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_hit ? '0 : r_pcnt + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/prescaled_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_updown_counter
// Purpose  : Up/down modulo counter stepped by a clock-enable prescaler.
//            Define PRESCALED_COUNTER_SATURATE_EN for saturating behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module prescaled_updown_counter
  import prescaled_counter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic          up,
  input  logic [PW-1:0] div,
  input  logic [N-1:0]  mod_max,
  output logic [N-1:0]  q,
  output logic          step_tick,
  output logic          wrap_tick,
  output logic          at_max,
  output logic          at_min
);

  logic [N-1:0] r_q;
  logic         r_step_tick;
  logic         r_wrap_tick;
  logic         w_step;
  count_res_t   w_res;
  logic [N-1:0] w_next_q;

  // load restarts the prescale period just like clr does.
  clk_en_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clr     (clr | load),
    .div     (div),
    .step    (w_step)
  );

  assign w_res    = next_count(CNT_W_MAX'(r_q), up, CNT_W_MAX'(mod_max));
  assign w_next_q = w_res.q[N-1:0];

  generate
    if (N < CNT_W_MAX) begin : g_hi_pad
      logic w_unused_hi;
      assign w_unused_hi = ^w_res.q[CNT_W_MAX-1:N];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= '0;
      r_step_tick <= 1'b0;
      r_wrap_tick <= 1'b0;
    end else if (clr) begin
      r_q         <= '0;
      r_step_tick <= 1'b0;
      r_wrap_tick <= 1'b0;
    end else if (load) begin
      r_q         <= load_val;
      r_step_tick <= 1'b0;
      r_wrap_tick <= 1'b0;
    end else if (w_step) begin
      r_q         <= w_next_q;
      r_step_tick <= 1'b1;
      r_wrap_tick <= w_res.wrap;
    end else begin
      r_step_tick <= 1'b0;
      r_wrap_tick <= 1'b0;
    end
  end

  assign q         = r_q;
  assign step_tick = r_step_tick;
  assign wrap_tick = r_wrap_tick;
  assign at_max    = (r_q == mod_max);
  assign at_min    = (r_q == '0);

endmodule
`default_nettype wire
